regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the multi-cycle cache core.
- Provides NUM_RD combinational read ports and two write ports: port A for ALU writeback and port B for memory/cache-fill writeback.
- Read ports bypass same-cycle writes, and register 0 is hardwired to zero.
- A per-register busy scoreboard tracks outstanding multi-cycle loads so the control FSM can stall dependent instructions.

Parameters:
- XLEN, 32, data width in bits.
- ADDR_W, 5, register address width; the file has 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..4).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i is bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*XLEN  read data, packed the same way as rd_addr
- rd_busy  out  NUM_RD  port i's register has an outstanding load that is not resolved this cycle
- wa_en  in  1  port A write enable
- wa_addr  in  ADDR_W  port A write address
- wa_data  in  XLEN  port A write data
- wb_en  in  1  port B write enable; also clears busy
- wb_addr  in  ADDR_W  port B write address
- wb_data  in  XLEN  port B write data
- mark_en  in  1  set busy on mark_addr (load issued)
- mark_addr  in  ADDR_W  register to mark busy
- busy_vec  out  2**ADDR_W  registered scoreboard state
- err_waw  out  1  registered one-cycle pulse on a port A write to a busy register

Behaviour:
- Clocking and reset:
  - Reset is synchronous and active-high on clock clk, and has priority over every write, mark and clear in the same cycle.
  - On reset, all registers become 0, busy_vec becomes 0 and err_waw becomes 0.
  - rd_data reflects the zeroed file, and rd_busy becomes 0, from the cycle after reset.
  - Reset mid-load drops the busy bit; a later wb_en to that register still writes the data.
- Reads (combinational, zero latency), priority per port i:
  - rd_addr == 0 → data 0.
  - Else wa_en && wa_addr == rd_addr → wa_data.
  - Else wb_en && wb_addr == rd_addr → wb_data.
  - Else the stored value.
- Writes (at posedge clk, when reset is low):
  - Port A writes mem[wa_addr]; port B writes mem[wb_addr].
  - Same address on both ports in the same cycle: port A data wins. The busy clear from port B still happens.
  - Writes to address 0 are ignored.
- Scoreboard (at posedge clk):
  - mark_en sets busy[mark_addr].
  - wb_en clears busy[wb_addr].
  - mark_en and wb_en to the same address in the same cycle: the register stays busy (mark wins; a new load was issued).
  - Marks of address 0 are ignored; busy[0] is always 0.
  - Port A writes never change busy.
- rd_busy[i] = busy[rd_addr_i] && !(wb_en && wb_addr == rd_addr_i). A same-cycle port B writeback resolves the dependency through the bypass.
- err_waw:
  - Registered; equals 1 in the cycle after wa_en && wa_addr != 0 && busy[wa_addr], otherwise 0.
  - The port A write still takes effect.
  - Diagnostic only; the control FSM is responsible for stalling.
- busy_vec exposes the registered busy bits directly.
- No initial-value preload: contents are 0 only after reset, and are X before the first reset in simulation.

Test Plan:
- Reset behaviour: pulse reset for 1 cycle, then read all 32 registers → every rd_data = 0, busy_vec = 0, err_waw = 0. Also assert reset together with wa_en to r3 = 0xDEAD → r3 reads 0 after the cycle.
- Write, read and bypass: write wa r5 = 0x12345678. Next cycle rd_addr0 = 5 → 0x12345678. In the same cycle wb_en r5 = 0xCAFEF00D with rd_addr1 = 5 → rd_data1 = 0xCAFEF00D combinationally, and 0xCAFEF00D is stored after the edge.
- Register 0: wa_en r0 = 0xFFFFFFFF and mark_en r0 → r0 reads 0 on every port, and busy_vec[0] = 0.
- Load scoreboard:
  - mark r7 → busy_vec[7] = 1 and rd_busy = 1 for a port reading 7.
  - Three cycles later, wb_en r7 = 0x77 → rd_busy = 0 in that cycle with rd_data = 0x77, and busy_vec[7] = 0 after the edge.
  - In one cycle, mark r7 and wb_en r7 together → busy_vec[7] stays 1.
- Conflicts and error pulse:
  - wa and wb both to r9 (0xA, 0xB) with r9 busy → r9 = 0xA and busy cleared.
  - With r4 busy, wa_en r4 = 0x1 → err_waw = 1 for exactly one cycle, r4 = 0x1, and busy_vec[4] remains 1.
- Reset mid-load: mark r2, then reset → busy_vec = 0. A following wb_en r2 = 0x55 → r2 reads 0x55 and err_waw stays 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with two write ports, same-cycle read bypass, hardwired r0
// and a per-register busy scoreboard for outstanding multi-cycle loads.
module regfile_scoreboard #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*XLEN-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wa_en_i,
    input  logic [ADDR_W-1:0]        wa_addr_i,
    input  logic [XLEN-1:0]          wa_data_i,
    input  logic                     wb_en_i,
    input  logic [ADDR_W-1:0]        wb_addr_i,
    input  logic [XLEN-1:0]          wb_data_i,
    input  logic                     mark_en_i,
    input  logic [ADDR_W-1:0]        mark_addr_i,
    output logic [2**ADDR_W-1:0]     busy_vec_o,
    output logic                     err_waw_o
);

    localparam int unsigned NumRegs = 2**ADDR_W;

    logic [XLEN-1:0]    mem_q [NumRegs];
    logic [NumRegs-1:0] busy_q, busy_d;
    logic               err_waw_q, err_waw_d;

    logic wa_live, wb_live;
    assign wa_live = wa_en_i && (wa_addr_i != '0);
    assign wb_live = wb_en_i && (wb_addr_i != '0);

    // Port B first so a same-address port A write overrides it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wb_live) begin
                mem_q[wb_addr_i] <= wb_data_i;
            end
            if (wa_live) begin
                mem_q[wa_addr_i] <= wa_data_i;
            end
        end
    end

    // Clear before set: a new load issued alongside the writeback keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_en_i) begin
            busy_d[wb_addr_i] = 1'b0;
        end
        if (mark_en_i) begin
            busy_d[mark_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    assign err_waw_d = wa_live && busy_q[wa_addr_i];

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q    <= '0;
            err_waw_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            err_waw_q <= err_waw_d;
        end
    end

    assign busy_vec_o = busy_q;
    assign err_waw_o  = err_waw_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit_a, hit_b;

        assign ra    = rd_addr_i[i*ADDR_W +: ADDR_W];
        assign hit_a = wa_en_i && (wa_addr_i == ra);
        assign hit_b = wb_en_i && (wb_addr_i == ra);

        assign rd_data_o[i*XLEN +: XLEN] = (ra == '0) ? '0        :
                                           hit_a      ? wa_data_i :
                                           hit_b      ? wb_data_i :
                                                        mem_q[ra];
        assign rd_busy_o[i] = busy_q[ra] && !hit_b;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: expectations are queued as stimulus is driven
// and popped against the DUT outputs once they settle.
module tb_regfile_scoreboard;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM_RD = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*XLEN-1:0]   rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wa_en, wb_en, mark_en;
    logic [ADDR_W-1:0]        wa_addr, wb_addr, mark_addr;
    logic [XLEN-1:0]          wa_data, wb_data;
    logic [31:0]              busy_vec;
    logic                     err_waw;

    int n_tests = 0;
    int n_fail  = 0;

    string       tag_q[$];
    logic [63:0] exp_q[$];

    regfile_scoreboard #(
        .XLEN  (XLEN),
        .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_busy_o  (rd_busy),
        .wa_en_i    (wa_en),
        .wa_addr_i  (wa_addr),
        .wa_data_i  (wa_data),
        .wb_en_i    (wb_en),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .mark_en_i  (mark_en),
        .mark_addr_i(mark_addr),
        .busy_vec_o (busy_vec),
        .err_waw_o  (err_waw)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    function automatic logic [63:0] rd0();
        return {32'h0, rd_data[31:0]};
    endfunction

    function automatic logic [63:0] rd1();
        return {32'h0, rd_data[63:32]};
    endfunction

    initial begin
        reset = 1'b1;
        rd_addr = '0;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        mark_en = 1'b0; mark_addr = '0;

        // Reset: every register reads zero on both ports
        tick();
        tick();
        reset = 1'b0;
        for (int r = 0; r < 32; r++) begin
            set_rd(ADDR_W'(r), ADDR_W'(31 - r));
            push($sformatf("reset_rd0_r%0d", r), 64'h0);
            check(rd0());
            push($sformatf("reset_rd1_r%0d", 31 - r), 64'h0);
            check(rd1());
        end
        push("reset_busy_vec", 64'h0);
        check({32'h0, busy_vec});
        push("reset_err_waw", 64'h0);
        check({63'h0, err_waw});

        // Reset beats a simultaneous port A write
        reset = 1'b1; wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hDEAD;
        tick();
        reset = 1'b0; wa_en = 1'b0;
        set_rd(5'd3, 5'd0);
        push("reset_beats_write_r3", 64'h0);
        check(rd0());

        // Write, read back, then bypass from port B
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h12345678;
        tick();
        wa_en = 1'b0;
        set_rd(5'd5, 5'd0);
        push("wa_store_r5", 64'h12345678);
        check(rd0());
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hCAFEF00D;
        set_rd(5'd5, 5'd5);
        push("wb_bypass_rd1_r5", 64'hCAFEF00D);
        check(rd1());
        tick();
        wb_en = 1'b0;
        set_rd(5'd5, 5'd5);
        push("wb_store_r5", 64'hCAFEF00D);
        check(rd0());

        // Register 0 ignores writes and marks
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
        mark_en = 1'b1; mark_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        push("r0_bypass_rd0", 64'h0);
        check(rd0());
        push("r0_bypass_rd1", 64'h0);
        check(rd1());
        tick();
        wa_en = 1'b0; mark_en = 1'b0;
        set_rd(5'd0, 5'd0);
        push("r0_stored", 64'h0);
        check(rd1());
        push("r0_busy", 64'h0);
        check({63'h0, busy_vec[0]});

        // Load scoreboard on r7
        mark_en = 1'b1; mark_addr = 5'd7;
        tick();
        mark_en = 1'b0;
        set_rd(5'd0, 5'd7);
        push("mark_busy_vec7", 64'h1);
        check({63'h0, busy_vec[7]});
        push("mark_rd_busy1", 64'h1);
        check({63'h0, rd_busy[1]});
        push("mark_rd_busy0_r0", 64'h0);
        check({63'h0, rd_busy[0]});
        tick();
        tick();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
        set_rd(5'd0, 5'd7);
        push("wb_resolves_rd_busy1", 64'h0);
        check({63'h0, rd_busy[1]});
        push("wb_bypass_r7", 64'h77);
        check(rd1());
        push("wb_busy_vec7_before_edge", 64'h1);
        check({63'h0, busy_vec[7]});
        tick();
        wb_en = 1'b0;
        set_rd(5'd0, 5'd7);
        push("wb_clears_busy7", 64'h0);
        check({63'h0, busy_vec[7]});
        push("wb_stored_r7", 64'h77);
        check(rd1());
        mark_en = 1'b1; mark_addr = 5'd7;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h78;
        tick();
        mark_en = 1'b0; wb_en = 1'b0;
        set_rd(5'd0, 5'd7);
        push("mark_wins_busy7", 64'h1);
        check({63'h0, busy_vec[7]});
        push("mark_wins_rd_busy1", 64'h1);
        check({63'h0, rd_busy[1]});

        // Both write ports to busy r9: A data wins, B clears busy
        mark_en = 1'b1; mark_addr = 5'd9;
        tick();
        mark_en = 1'b0;
        wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'hA;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hB;
        set_rd(5'd9, 5'd0);
        push("dual_bypass_r9", 64'hA);
        check(rd0());
        tick();
        wa_en = 1'b0; wb_en = 1'b0;
        set_rd(5'd9, 5'd0);
        push("dual_store_r9", 64'hA);
        check(rd0());
        push("dual_busy9", 64'h0);
        check({63'h0, busy_vec[9]});
        push("dual_err_waw", 64'h1);
        check({63'h0, err_waw});
        tick();
        push("dual_err_waw_drop", 64'h0);
        check({63'h0, err_waw});

        // WAW error pulse on busy r4
        mark_en = 1'b1; mark_addr = 5'd4;
        tick();
        mark_en = 1'b0;
        push("waw_err_idle", 64'h0);
        check({63'h0, err_waw});
        wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h1;
        tick();
        wa_en = 1'b0;
        set_rd(5'd4, 5'd0);
        push("waw_err_pulse", 64'h1);
        check({63'h0, err_waw});
        push("waw_store_r4", 64'h1);
        check(rd0());
        push("waw_busy4_kept", 64'h1);
        check({63'h0, busy_vec[4]});
        tick();
        push("waw_err_one_cycle", 64'h0);
        check({63'h0, err_waw});

        // Reset mid-load drops busy; later writeback still lands
        mark_en = 1'b1; mark_addr = 5'd2;
        tick();
        mark_en = 1'b0;
        push("midload_busy2", 64'h1);
        check({63'h0, busy_vec[2]});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push("midload_reset_busy_vec", 64'h0);
        check({32'h0, busy_vec});
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h55;
        tick();
        wb_en = 1'b0;
        set_rd(5'd2, 5'd2);
        push("midload_wb_r2", 64'h55);
        check(rd0());
        push("midload_err_waw", 64'h0);
        check({63'h0, err_waw});
        push("midload_busy_vec", 64'h0);
        check({32'h0, busy_vec});

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
